// File: rtl/mips_register_file_if.sv
// mips_register_file_if: read/write/debug bus between pipeline stages and the register file
interface mips_register_file_if #(
    parameter int REGADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
);
    logic [REGADDR_WIDTH-1:0] read1_addr;
    logic [REGADDR_WIDTH-1:0] read2_addr;
    logic [REGADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [DATA_WIDTH-1:0]    data_out1;
    logic [DATA_WIDTH-1:0]    data_out2;
    logic [DATA_WIDTH-1:0]    debug_out;

    modport master (
        output read1_addr, read2_addr, write_addr, data_in,
        input  data_out1, data_out2, debug_out
    );

    modport slave (
        input  read1_addr, read2_addr, write_addr, data_in,
        output data_out1, data_out2, debug_out
    );
endinterface

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 register file, r0 hardwired to zero, write-through read bypass
module mips_register_file #(
    parameter int REGADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEBUG_REG     = 2
) (
    input logic                 clk,
    input logic                 rst,
    mips_register_file_if.slave bus
);
    localparam int NUM_REGS = 1 << REGADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic                  wr_en;

    assign wr_en = bus.write_addr != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.write_addr] <= bus.data_in;
        end
    end

    // Same-cycle write-back is forwarded so decode never sees a stale operand.
    always_comb begin
        bus.data_out1 = bus.read1_addr == '0 ? '0 :
                        (!rst && wr_en && bus.read1_addr == bus.write_addr) ? bus.data_in :
                        regs[bus.read1_addr];
        bus.data_out2 = bus.read2_addr == '0 ? '0 :
                        (!rst && wr_en && bus.read2_addr == bus.write_addr) ? bus.data_in :
                        regs[bus.read2_addr];
    end

    generate
        if (DEBUG_REG == 0) begin : g_dbg_zero
            assign bus.debug_out = '0;
        end else begin : g_dbg_reg
            assign bus.debug_out = regs[DEBUG_REG];
        end
    endgenerate
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: randomized and directed checks against an array-based register model
module tb_mips_register_file;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [32];

    mips_register_file_if bif ();

    mips_register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (!rst && bif.write_addr != 0 && a == bif.write_addr) return bif.data_in;
        return mdl[a];
    endfunction

    task automatic tick;
        @(posedge clk);
        if (rst) for (int i = 1; i < 32; i++) mdl[i] = 32'h0;
        else if (bif.write_addr != 0) mdl[bif.write_addr] = bif.data_in;
        #1;
    endtask

    task automatic test_reset;
        bif.write_addr = 5; bif.data_in = 32'hDEADBEEF;
        tick();
        rst = 1'b1; bif.write_addr = 0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bif.read1_addr = a[4:0]; bif.read2_addr = 5'(31 - a);
            #1;
            checks++;
            if (bif.data_out1 !== 32'h0) begin
                errors++; $display("FAIL reset_rd1 addr=%0d got=%h exp=00000000", a, bif.data_out1);
            end
            checks++;
            if (bif.data_out2 !== 32'h0) begin
                errors++; $display("FAIL reset_rd2 addr=%0d got=%h exp=00000000", 31 - a, bif.data_out2);
            end
        end
        checks++;
        if (bif.debug_out !== 32'h0) begin
            errors++; $display("FAIL reset_debug got=%h exp=00000000", bif.debug_out);
        end
    endtask

    task automatic test_basic;
        bif.write_addr = 7; bif.data_in = 32'h12345678;
        tick();
        bif.write_addr = 0; bif.read1_addr = 7; bif.read2_addr = 7;
        #1;
        checks++;
        if (bif.data_out1 !== 32'h12345678 || bif.data_out2 !== 32'h12345678) begin
            errors++; $display("FAIL basic_r7 got1=%h got2=%h exp=12345678", bif.data_out1, bif.data_out2);
        end
        bif.write_addr = 8; bif.data_in = 32'hCAFEBABE;
        tick();
        bif.write_addr = 0; bif.read2_addr = 8;
        #1;
        checks++;
        if (bif.data_out2 !== 32'hCAFEBABE) begin
            errors++; $display("FAIL basic_r8 got=%h exp=cafebabe", bif.data_out2);
        end
        checks++;
        if (bif.data_out1 !== 32'h12345678) begin
            errors++; $display("FAIL basic_r7_kept got=%h exp=12345678", bif.data_out1);
        end
    endtask

    task automatic test_r0;
        bif.write_addr = 0; bif.data_in = 32'hFFFFFFFF; bif.read1_addr = 0;
        #1;
        checks++;
        if (bif.data_out1 !== 32'h0) begin
            errors++; $display("FAIL r0_same got=%h exp=00000000", bif.data_out1);
        end
        tick();
        checks++;
        if (bif.data_out1 !== 32'h0) begin
            errors++; $display("FAIL r0_next got=%h exp=00000000", bif.data_out1);
        end
    endtask

    task automatic test_bypass;
        bif.write_addr = 9; bif.data_in = 32'h11111111;
        tick();
        bif.data_in = 32'h22222222; bif.read1_addr = 9; bif.read2_addr = 9;
        #1;
        checks++;
        if (bif.data_out1 !== 32'h22222222 || bif.data_out2 !== 32'h22222222) begin
            errors++; $display("FAIL bypass_same got1=%h got2=%h exp=22222222", bif.data_out1, bif.data_out2);
        end
        tick();
        bif.write_addr = 0;
        #1;
        checks++;
        if (bif.data_out1 !== 32'h22222222) begin
            errors++; $display("FAIL bypass_stored got=%h exp=22222222", bif.data_out1);
        end
    endtask

    task automatic test_reset_collision;
        bif.write_addr = 4; bif.data_in = 32'h0BADF00D;
        tick();
        rst = 1'b1; bif.write_addr = 3; bif.data_in = 32'hAAAA5555;
        bif.read1_addr = 3; bif.read2_addr = 4;
        #1;
        checks++;
        if (bif.data_out1 !== 32'h0) begin
            errors++; $display("FAIL coll_rd_during_rst got=%h exp=00000000", bif.data_out1);
        end
        checks++;
        if (bif.data_out2 !== 32'h0BADF00D) begin
            errors++; $display("FAIL coll_stored_during_rst got=%h exp=0badf00d", bif.data_out2);
        end
        tick();
        rst = 1'b0; bif.write_addr = 0;
        #1;
        checks++;
        if (bif.data_out1 !== 32'h0 || bif.data_out2 !== 32'h0) begin
            errors++; $display("FAIL coll_after got1=%h got2=%h exp=00000000", bif.data_out1, bif.data_out2);
        end
    endtask

    task automatic test_debug;
        bif.write_addr = 2; bif.data_in = 32'h0000ABCD;
        #1;
        checks++;
        if (bif.debug_out !== 32'h0) begin
            errors++; $display("FAIL debug_no_bypass got=%h exp=00000000", bif.debug_out);
        end
        tick();
        bif.write_addr = 3; bif.data_in = 32'h00001234;
        #1;
        checks++;
        if (bif.debug_out !== 32'h0000ABCD) begin
            errors++; $display("FAIL debug_after got=%h exp=0000abcd", bif.debug_out);
        end
        tick();
        bif.write_addr = 0;
        checks++;
        if (bif.debug_out !== 32'h0000ABCD) begin
            errors++; $display("FAIL debug_r3_write got=%h exp=0000abcd", bif.debug_out);
        end
    endtask

    task automatic test_random;
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bif.write_addr = 5'($urandom_range(0, 31));
            bif.data_in = $urandom;
            bif.read1_addr = ($urandom_range(0, 3) == 0) ? bif.write_addr : 5'($urandom_range(0, 31));
            bif.read2_addr = ($urandom_range(0, 3) == 0) ? bif.read1_addr : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(bif.read1_addr);
            e2 = exp_rd(bif.read2_addr);
            checks++;
            if (bif.data_out1 !== e1) begin
                errors++; $display("FAIL rand_rd1 n=%0d addr=%0d got=%h exp=%h", n, bif.read1_addr, bif.data_out1, e1);
            end
            checks++;
            if (bif.data_out2 !== e2) begin
                errors++; $display("FAIL rand_rd2 n=%0d addr=%0d got=%h exp=%h", n, bif.read2_addr, bif.data_out2, e2);
            end
            checks++;
            if (bif.debug_out !== mdl[2]) begin
                errors++; $display("FAIL rand_debug n=%0d got=%h exp=%h", n, bif.debug_out, mdl[2]);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        bif.read1_addr = 0; bif.read2_addr = 0; bif.write_addr = 0; bif.data_in = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_r0();
        test_bypass();
        test_reset_collision();
        test_debug();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
